pong_text_overlay: RTL and testbench
====================================

# pong_text_overlay

Parametrised, runtime-configurable text overlay engine for the pong VGA pipeline. Renders a COLS×ROWS character window, held in an internal writable character buffer, at a programmable origin and integer scale. It drives an external synchronous font ROM and outputs a pipelined per-pixel text_on/text_rgb for the pixel mux. It replaces hard-coded text regions with one window per instance: score line, rules and game-over are separate instances, each loaded by game logic. It adds frame-synchronous config, hardware blink and auto-clear.

## Interface
- COLS, 16, characters per row
- ROWS, 4, character rows
- FG_RGB, 3'b001, glyph pixel colour
- BG_RGB, 3'b110, background colour
- BLINK_FRAMES, 30, frames per blink half-period (≥1)
- clk  in  1  pixel clock (one clock domain)
- rst_n  in  1  reset, asynchronous assert, active-low
- pixel_x, pixel_y  in  10 each  current pixel coordinate
- frame_start  in  1  one-cycle pulse at start of each frame
- cfg_we  in  1  capture cfg_* into pending registers
- cfg_origin_x, cfg_origin_y  in  10 each  window top-left pixel
- cfg_scale  in  2  scale shift s; cell = (8<<s)×(16<<s)
- cfg_blink  in  1  enable blink
- clr  in  1  pulse: clear buffer to 7'h00
- wr_valid  in  1  char write request
- wr_ready  out  1  buffer accepting writes
- wr_addr  in  $clog2(COLS*ROWS)  row*COLS+col
- wr_char  in  7  ASCII code
- font_addr  out  11  {char, font_row} to font ROM
- font_data  in  8  ROM word, 1-cycle read latency
- text_on  out  1  pixel inside visible window
- text_rgb  out  3  overlay colour

## Operation
- Buffer FSM states CLEAR, IDLE. Reset enters CLEAR with ptr=0. CLEAR writes 7'h00 at ptr, one entry per cycle. After entry COLS*ROWS-1, go to IDLE.
- wr_ready = (state==IDLE). A write is accepted on wr_valid&&wr_ready. If wr_addr ≥ COLS*ROWS, the write is accepted and dropped.
- clr in IDLE: the same-cycle accepted write completes, then CLEAR starts next cycle. clr in CLEAR restarts ptr at 0.
- cfg_we loads the pending registers. On frame_start, active ← pending; if cfg_we and frame_start coincide, active takes the new cfg values. Reset values are origin 0,0, scale 0, blink 0 for both pending and active.
- Blink: a counter increments on each frame_start and wraps at BLINK_FRAMES-1, toggling phase. Counter and phase reset to 0. hidden = active_blink && phase.
- Geometry is 11-bit signed: dx = pixel_x − origin_x, dy = pixel_y − origin_y. in_box = dx≥0 && dy≥0 && dx < COLS<<(3+s) && dy < ROWS<<(4+s).
- col = dx>>(3+s); row = dy>>(4+s); font_row = (dy>>s)[3:0]; bit = (dx>>s)[2:0], MSB = leftmost pixel, so use font_data[7−bit].
- text_on = in_box && !hidden. text_rgb = (text_on && glyph bit) ? FG_RGB : BG_RGB.
- Pixel reads come from a separate read port and are unaffected by writes or clears. A read and a write to the same address in the same cycle returns the old data.

## Timing
- Latency is 3 cycles from pixel_x/y to text_on/text_rgb. Cycle t+1: char read registered, with font_row, bit, in_box and hidden delayed alongside. font_addr is driven from the t+1 registers. t+2: font_data is valid and the pipeline delays again. t+3: outputs registered.
- Reset values: text_on 0, text_rgb BG_RGB, font_addr 0, wr_ready 0.
- wr_ready rises exactly COLS*ROWS cycles after rst_n deasserts (64 cycles at defaults).
- Config and blink changes take effect for pixels sampled from the cycle after frame_start onward.
- Reset asserted mid-clear or mid-frame drops all state immediately, and a fresh clear starts on release.

## Structure
- Package pong_text_pkg holds:
  - rgb_t (3b) and char_t (7b) types
  - buf_state_t {CLEAR, IDLE}
  - FONT_W=8 and FONT_H=16
  - CHAR_BLANK=7'h00
- Sub-module text_char_buffer: simple dual-port RAM, COLS*ROWS×7, one sync write port, one sync read port.
- The existing font_rom is instantiated outside this block, in the text top level, and connected via font_addr/font_data.

## Test plan
- Reset release: wr_ready=0 for 64 cycles, then 1. All rendered pixels are BG_RGB, with text_on=1 inside the window.
- Write 'S' (7'h53) at addr 0, scale 1, origin (0,0), frame_start. Pixel (x,y) maps to ROM word for char 0x53, row y[4:1], bit x[3:1]. font_addr = {7'h53, y[4:1]} 1 cycle later; text_rgb matches the bit 3 cycles later.
- Origin (100,50), scale 2, COLS=16, ROWS=4. text_on=1 at (100,50) and (611,305); text_on=0 at (99,50), (612,50) and (100,306).
- cfg_we with origin 200 mid-frame: rendering keeps origin 0 until the next frame_start, then shifts.
- cfg_blink=1, BLINK_FRAMES=2: text_on pattern over frames is visible for 2 frames, hidden for 2, visible for 2.
- clr issued with a simultaneous write to addr 5: write accepted, wr_ready low 64 cycles, addr 5 reads back blank. clr again at ptr 10 restarts the clear, keeping wr_ready low 64 more cycles.

Source files
------------

// File: rtl/pong_text_pkg.sv
// Shared types and constants for the pong text overlay.
package pong_text_pkg;

  localparam int unsigned FONT_W  = 8;
  localparam int unsigned FONT_H  = 16;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned GEO_W   = 11;
  localparam int unsigned CHAR_W  = 7;
  localparam int unsigned RGB_W   = 3;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [CHAR_W-1:0] char_t;

  typedef enum logic {
    CLEAR,
    IDLE
  } buf_state_t;

  localparam char_t CHAR_BLANK = 7'h00;

  // Window configuration, captured as pending and promoted to active per frame.
  typedef struct packed {
    logic [COORD_W-1:0] origin_x;
    logic [COORD_W-1:0] origin_y;
    logic [1:0]         scale;
    logic               blink;
  } cfg_t;

endpackage

// File: rtl/pong_text_overlay_if.sv
// Character write / clear bus between game logic and one overlay instance.
interface pong_text_overlay_if #(
  parameter int unsigned ADDR_W = 6
);
  import pong_text_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  char_t             wr_char;
  logic              clr;

  modport master (
    output wr_valid, wr_addr, wr_char, clr,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_char, clr,
    output wr_ready
  );

endinterface

// File: rtl/text_char_buffer.sv
// Simple dual-port character RAM: one sync write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module text_char_buffer import pong_text_pkg::*; #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  char_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output char_t             o_rdata
);

  char_t r_mem [DEPTH];

  // Write port; storage itself is not reset, the owner clears it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port, registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= CHAR_BLANK;
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/pong_text_overlay.sv
// Text window overlay: character buffer, frame-synced config, blink and a
// 3-stage pixel pipeline driving an external synchronous font ROM.
module pong_text_overlay import pong_text_pkg::*; #(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 4,
  parameter rgb_t        FG_RGB       = 3'b001,
  parameter rgb_t        BG_RGB       = 3'b110,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic                 frame_start,
  input  logic                 cfg_we,
  input  logic [COORD_W-1:0]   cfg_origin_x,
  input  logic [COORD_W-1:0]   cfg_origin_y,
  input  logic [1:0]           cfg_scale,
  input  logic                 cfg_blink,
  pong_text_overlay_if.slave   wr_bus,
  output logic [10:0]          font_addr,
  input  logic [FONT_W-1:0]    font_data,
  output logic                 text_on,
  output rgb_t                 text_rgb
);

  localparam int unsigned DEPTH   = COLS * ROWS;
  localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CX_SH   = $clog2(FONT_W);
  localparam int unsigned CY_SH   = $clog2(FONT_H);
  localparam int unsigned LIM_W   = 12;
  localparam int unsigned LIN_W   = 16;
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned BIT_MSB = FONT_W - 1;

  // ---------------- buffer fill / clear FSM ----------------
  buf_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  char_t             w_ram_wdata;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_raddr;
  char_t             w_rchar;

  assign w_addr_ok      = (ADDR_W+1)'(wr_bus.wr_addr) < (ADDR_W+1)'(DEPTH);
  assign wr_bus.wr_ready = (r_state == IDLE);

  // State register: reset always starts a fresh clear from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state and RAM write port selection.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_ptr;
    w_ram_wdata = CHAR_BLANK;
    unique case (r_state)
      CLEAR: begin
        w_ram_we = 1'b1;
        if (wr_bus.clr) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        // Out-of-range addresses are accepted but never reach the RAM.
        if (wr_bus.wr_valid && w_addr_ok) begin
          w_ram_we    = 1'b1;
          w_ram_waddr = wr_bus.wr_addr;
          w_ram_wdata = wr_bus.wr_char;
        end
        if (wr_bus.clr) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  text_char_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rchar)
  );

  // ---------------- configuration and blink ----------------
  cfg_t               w_cfg_in, r_cfg_pend, r_cfg_act;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;

  assign w_cfg_in = '{origin_x: cfg_origin_x, origin_y: cfg_origin_y,
                      scale: cfg_scale, blink: cfg_blink};

  // Pending config on cfg_we; promoted to active at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_pend <= '0;
      r_cfg_act  <= '0;
    end else begin
      if (cfg_we) begin
        r_cfg_pend <= w_cfg_in;
      end
      if (frame_start) begin
        r_cfg_act <= cfg_we ? w_cfg_in : r_cfg_pend;
      end
    end
  end

  // Frame counter toggling the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (frame_start) begin
      if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // ---------------- stage 0: geometry ----------------
  logic signed [GEO_W-1:0] w_dx, w_dy;
  logic [3:0]              w_xsh, w_ysh;
  logic [LIM_W-1:0]        w_xlim, w_ylim;
  logic                    w_in_box, w_hidden;
  logic [COORD_W-1:0]      w_col, w_row;
  logic [3:0]              w_font_row;
  logic [2:0]              w_bit;

  assign w_dx   = $signed({1'b0, pixel_x}) - $signed({1'b0, r_cfg_act.origin_x});
  assign w_dy   = $signed({1'b0, pixel_y}) - $signed({1'b0, r_cfg_act.origin_y});
  assign w_xsh  = 4'(CX_SH) + 4'(r_cfg_act.scale);
  assign w_ysh  = 4'(CY_SH) + 4'(r_cfg_act.scale);
  assign w_xlim = LIM_W'(COLS) << w_xsh;
  assign w_ylim = LIM_W'(ROWS) << w_ysh;

  assign w_in_box = !w_dx[GEO_W-1] && !w_dy[GEO_W-1]
                    && (LIM_W'(w_dx[GEO_W-2:0]) < w_xlim)
                    && (LIM_W'(w_dy[GEO_W-2:0]) < w_ylim);

  assign w_col      = w_dx[GEO_W-2:0] >> w_xsh;
  assign w_row      = w_dy[GEO_W-2:0] >> w_ysh;
  assign w_font_row = 4'(w_dy[GEO_W-2:0] >> r_cfg_act.scale);
  assign w_bit      = 3'(w_dx[GEO_W-2:0] >> r_cfg_act.scale);
  assign w_hidden   = r_cfg_act.blink && r_phase;
  assign w_raddr    = w_in_box
                      ? ADDR_W'(LIN_W'(w_row) * LIN_W'(COLS) + LIN_W'(w_col))
                      : '0;

  // ---------------- stages 1..3 ----------------
  logic [3:0] r1_font_row;
  logic [2:0] r1_bit, r2_bit;
  logic       r1_in_box, r2_in_box;
  logic       r1_hidden, r2_hidden;
  logic       w_on, w_glyph;

  assign font_addr = {w_rchar, r1_font_row};
  assign w_on      = r2_in_box && !r2_hidden;
  assign w_glyph   = font_data[3'(BIT_MSB) - r2_bit];

  // Delay pixel attributes alongside the char read and the font ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_font_row <= '0;
      r1_bit      <= '0;
      r1_in_box   <= 1'b0;
      r1_hidden   <= 1'b0;
      r2_bit      <= '0;
      r2_in_box   <= 1'b0;
      r2_hidden   <= 1'b0;
    end else begin
      r1_font_row <= w_font_row;
      r1_bit      <= w_bit;
      r1_in_box   <= w_in_box;
      r1_hidden   <= w_hidden;
      r2_bit      <= r1_bit;
      r2_in_box   <= r1_in_box;
      r2_hidden   <= r1_hidden;
    end
  end

  // Output register: colour per glyph bit inside a visible window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_on  <= 1'b0;
      text_rgb <= BG_RGB;
    end else begin
      text_on  <= w_on;
      text_rgb <= (w_on && w_glyph) ? FG_RGB : BG_RGB;
    end
  end

endmodule

// File: tb/tb_pong_text_overlay.sv
// Directed bench for pong_text_overlay with a pixel scoreboard and font ROM model.
module tb_pong_text_overlay;
  import pong_text_pkg::*;

  localparam int   COLS  = 16;
  localparam int   ROWS  = 4;
  localparam int   DEPTH = COLS * ROWS;
  localparam int   BF    = 2;
  localparam rgb_t FG    = 3'b001;
  localparam rgb_t BG    = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        frame_start = 1'b0, cfg_we = 1'b0, cfg_blink = 1'b0;
  logic [9:0]  cfg_origin_x = '0, cfg_origin_y = '0;
  logic [1:0]  cfg_scale = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        text_on;
  rgb_t        text_rgb;

  pong_text_overlay_if #(.ADDR_W(6)) bus ();

  pong_text_overlay #(
    .COLS(COLS), .ROWS(ROWS), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_origin_x(cfg_origin_x),
    .cfg_origin_y(cfg_origin_y), .cfg_scale(cfg_scale), .cfg_blink(cfg_blink),
    .wr_bus(bus), .font_addr(font_addr), .font_data(font_data),
    .text_on(text_on), .text_rgb(text_rgb)
  );

  always #5 clk = ~clk;

  // External font ROM stand-in; char 0 is an empty glyph.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    int v;
    v = int'(a);
    if (a[10:4] == 7'h00) return 8'h00;
    return 8'((v * 73) ^ (v >> 3) ^ 'h5A);
  endfunction

  always @(posedge clk) font_data <= rom_fn(font_addr);

  typedef struct { int due; int x; int y; logic on; rgb_t rgb; } pix_exp_t;
  typedef struct { int due; int x; int y; logic [10:0] fa; } fa_exp_t;
  pix_exp_t sbq[$];
  fa_exp_t  faq[$];

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;

  // Reference state
  logic [6:0] m_mem [DEPTH];
  int  m_ox = 0, m_oy = 0, m_s = 0, p_ox = 0, p_oy = 0, p_s = 0;
  bit  m_blink = 0, p_blink = 0, m_phase = 0;
  int  m_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; compare scoreboard entries due in this cycle.
  task automatic tick();
    pix_exp_t p;
    fa_exp_t  f;
    @(posedge clk);
    #1;
    cyc++;
    while (faq.size() > 0 && faq[0].due == cyc) begin
      f = faq.pop_front();
      chk($sformatf("font_addr(%0d,%0d)", f.x, f.y), int'(font_addr), int'(f.fa));
    end
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      p = sbq.pop_front();
      chk($sformatf("text_on(%0d,%0d)", p.x, p.y), int'(text_on), int'(p.on));
      chk($sformatf("text_rgb(%0d,%0d)", p.x, p.y), int'(text_rgb), int'(p.rgb));
    end
  endtask

  function automatic void exp_pix(input int x, input int y, output logic on,
                                  output rgb_t rgb, output logic [10:0] fa, output bit inb);
    int dx, dy, cw, ch, k, frow, b;
    logic [6:0] c;
    logic [7:0] w;
    k  = 1 << m_s;
    cw = 8 * k;
    ch = 16 * k;
    dx = x - m_ox;
    dy = y - m_oy;
    inb = (dx >= 0) && (dy >= 0) && (dx < COLS * cw) && (dy < ROWS * ch);
    on  = inb && !(m_blink && m_phase);
    rgb = BG;
    fa  = '0;
    if (inb) begin
      c    = m_mem[(dy / ch) * COLS + dx / cw];
      frow = (dy / k) % 16;
      b    = (dx / k) % 8;
      fa   = {c, 4'(frow)};
      w    = rom_fn(fa);
      if (on && w[7-b]) rgb = FG;
    end
  endfunction

  task automatic pix(input int x, input int y);
    logic on;
    rgb_t rgb;
    logic [10:0] fa;
    bit inb;
    exp_pix(x, y, on, rgb, fa, inb);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    sbq.push_back('{cyc + 3, x, y, on, rgb});
    if (inb) faq.push_back('{cyc + 1, x, y, fa});
    tick();
  endtask

  task automatic wr(input int a, input logic [6:0] c, input bit with_clr);
    int n;
    n = 0;
    while (!bus.wr_ready && n < 300) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", int'(bus.wr_ready), 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'(a);
    bus.wr_char  = c;
    bus.clr      = with_clr;
    tick();
    bus.wr_valid = 1'b0;
    bus.clr      = 1'b0;
    if (a < DEPTH) m_mem[a] = c;
    if (with_clr) foreach (m_mem[i]) m_mem[i] = 7'h00;
  endtask

  task automatic set_cfg(input int ox, input int oy, input int s, input bit bl);
    cfg_we       = 1'b1;
    cfg_origin_x = 10'(ox);
    cfg_origin_y = 10'(oy);
    cfg_scale    = 2'(s);
    cfg_blink    = bl;
  endtask

  task automatic frame(input bit we, input int ox, input int oy, input int s, input bit bl);
    if (we) set_cfg(ox, oy, s, bl);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_we      = 1'b0;
    if (we) begin p_ox = ox; p_oy = oy; p_s = s; p_blink = bl; end
    m_ox = p_ox; m_oy = p_oy; m_s = p_s; m_blink = p_blink;
    if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = !m_phase; end
    else m_cnt++;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_char  = '0;
    bus.clr      = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 7'h00;

    // Reset values
    repeat (3) tick();
    chk("rst_wr_ready", int'(bus.wr_ready), 0);
    chk("rst_text_on", int'(text_on), 0);
    chk("rst_text_rgb", int'(text_rgb), int'(BG));
    chk("rst_font_addr", int'(font_addr), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 1 || i == 63) chk($sformatf("init_clear_ready_c%0d", i), int'(bus.wr_ready), 0);
      if (i == 64) chk("init_clear_ready_c64", int'(bus.wr_ready), 1);
    end

    // Blank buffer renders as background, window edges at scale 0
    pix(5, 5); pix(127, 63); pix(128, 0); pix(0, 64); pix(60, 30);

    // Glyph rendering at scale 1
    wr(0, 7'h53, 0); wr(17, 7'h41, 0); wr(63, 7'h5A, 0); wr(5, 7'h33, 0);
    frame(1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) pix(i, 2 * i + (i % 2));
    pix(20, 40); pix(250, 100); pix(85, 7);
    for (int i = 0; i < 12; i++) pix(int'($urandom_range(0, 300)), int'($urandom_range(0, 150)));

    // Origin (100,50) at scale 2: window boundaries
    frame(1, 100, 50, 2, 0);
    pix(100, 50); pix(611, 305); pix(99, 50); pix(612, 50); pix(100, 306);
    for (int i = 0; i < 10; i++) pix(int'($urandom_range(80, 640)), int'($urandom_range(40, 320)));

    // Mid-frame config waits for the next frame start
    frame(1, 0, 0, 0, 0);
    set_cfg(200, 0, 0, 0);
    tick();
    cfg_we = 1'b0;
    p_ox = 200; p_oy = 0; p_s = 0; p_blink = 0;
    pix(3, 3); pix(199, 10); pix(210, 10);
    frame(0, 0, 0, 0, 0);
    pix(3, 3); pix(199, 10); pix(210, 10);

    // Blink over several frames
    frame(1, 0, 0, 0, 1);
    for (int f = 0; f < 6; f++) begin
      pix(3, 3); pix(8, 20);
      frame(0, 0, 0, 0, 0);
    end
    frame(1, 0, 0, 0, 0);

    // Clear with a simultaneous write to addr 5
    wr(5, 7'h77, 1);
    chk("clr1_ready_c0", int'(bus.wr_ready), 0);
    for (int j = 1; j <= 64; j++) begin
      tick();
      if (j == 63) chk("clr1_ready_c63", int'(bus.wr_ready), 0);
      if (j == 64) chk("clr1_ready_c64", int'(bus.wr_ready), 1);
    end
    pix(43, 4); pix(2, 2);

    // Clear restarted at ptr 10
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (10) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr2_ready_c0", int'(bus.wr_ready), 0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) chk("clr2_ready_c63", int'(bus.wr_ready), 0);
      if (k == 64) chk("clr2_ready_c64", int'(bus.wr_ready), 1);
    end
    wr(1, 7'h53, 0);
    pix(10, 3); pix(12, 9); pix(43, 4);

    repeat (5) tick();
    chk("scoreboard_drained", sbq.size() + faq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
